matrix_result_serializer: RTL and testbench



---
 rtl/matrix_result_serializer.sv | 191 +++++++++++++++++++
 tb/tb_matrix_result_serializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_serializer.sv
// ---------------------------------------------------------------------------
// matrix_result_serializer
//
// Sits after matrix_multiplier. It captures one packed result matrix on the
// multiplier's out_ready/out_ack four-phase handshake. It holds that matrix in
// a single-frame buffer. It then streams the matrix one element per beat over
// a valid/ready interface. Because the ack is raised at capture, the
// multiplier is free to start its next job while this frame drains.
//
// Build option:
//   MATRIX_SER_COLMAJOR_EN  defined   -> elements emitted column-major
//                           undefined -> elements emitted row-major (default)
//   out_last always marks element (R-1,C-1), which is the final beat in
//   either order.
//
// Parameters:
//   NUM_ROWS, NUM_COLS  result matrix shape
//   WORD_WIDTH          element width (IEEE-754 single by default)
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   In             packed matrix; element (r,c) is word r*NUM_COLS+c from MSB
//   in_ready       multiplier result valid (its out_ready)
//   in_ack         capture acknowledge (drives multiplier out_ack)
//   out_word       current element
//   out_valid      out_word valid
//   out_ready      downstream accepts the current beat
//   out_last       high with the final element of a frame
//   out_frame_cnt  completed-frame counter, wraps 255 -> 0
// ---------------------------------------------------------------------------
module matrix_result_serializer #(
    parameter int NUM_ROWS   = 2,
    parameter int NUM_COLS   = 2,
    parameter int WORD_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_ROWS*NUM_COLS*WORD_WIDTH-1:0] In,
    input  logic                                   in_ready,
    output logic                                   in_ack,
    output logic [WORD_WIDTH-1:0]                  out_word,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic [7:0]                             out_frame_cnt
);

    localparam int NUM_ELEMS = NUM_ROWS * NUM_COLS;
    localparam int IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam int ROW_W     = (NUM_ROWS  > 1) ? $clog2(NUM_ROWS)  : 1;
    localparam int COL_W     = (NUM_COLS  > 1) ? $clog2(NUM_COLS)  : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ELEMS - 1);
`ifdef MATRIX_SER_COLMAJOR_EN
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
`else
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
`endif

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [ROW_W-1:0]        row_q;
    logic [COL_W-1:0]        col_q;
    logic [WORD_WIDTH-1:0]   frame_p0 [NUM_ELEMS];
    logic                    in_ack_q;
    logic [7:0]              frame_cnt_q;

    logic                    capture;
    logic                    beat;
    logic                    last_beat;
    logic [IDX_W-1:0]        elem_sel;

    // A result still presented under an unreleased ack must not be taken
    // twice, so capture also waits for the ack to have dropped.
    assign capture   = (state_q == ST_IDLE) && in_ready && !in_ack_q;
    assign beat      = (state_q == ST_STREAM) && out_ready;
    // The beat counter tracks frame progress independent of emission order.
    assign last_beat = (idx_q == IDX_LAST);
    assign elem_sel  = IDX_W'(row_q) * IDX_W'(NUM_COLS) + IDX_W'(col_q);

    assign in_ack        = in_ack_q;
    assign out_frame_cnt = frame_cnt_q;

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM next state and stream outputs ----
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_word  = '0;
        out_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                out_word  = frame_p0[elem_sel];
                out_last  = last_beat;
                if (beat && last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---- Capture stage: frame buffer, written only on the capture edge ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < NUM_ELEMS; e++) begin
                frame_p0[e] <= '0;
            end
        end else if (capture) begin
            for (int e = 0; e < NUM_ELEMS; e++) begin
                frame_p0[e] <= In[(NUM_ELEMS-1-e)*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // ---- Element walk: beat counter plus row/column pointers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            row_q <= '0;
            col_q <= '0;
        end else if (capture) begin
            idx_q <= '0;
            row_q <= '0;
            col_q <= '0;
        end else if (beat) begin
            // The pointers may step past the matrix on the final beat; they
            // are not used in IDLE and are cleared on the next capture.
            idx_q <= idx_q + 1'b1;
`ifdef MATRIX_SER_COLMAJOR_EN
            if (row_q == ROW_LAST) begin
                row_q <= '0;
                col_q <= col_q + 1'b1;
            end else begin
                row_q <= row_q + 1'b1;
            end
`else
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
`endif
        end
    end

    // ---- Ack handshake: set on capture, released once in_ready is seen low ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ack_q <= 1'b0;
        end else if (capture) begin
            in_ack_q <= 1'b1;
        end else if (!in_ready) begin
            in_ack_q <= 1'b0;
        end
    end

    // ---- Frame counter: bumps on the edge that accepts out_last ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= 8'd0;
        end else if (beat && last_beat) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_matrix_result_serializer
//
// Directed bench for matrix_result_serializer with the default 2x2 x 32-bit
// configuration. It covers reset values, a basic frame, backpressure, a held
// in_ready, a reset in the middle of a frame, the element order for the
// active build, and the wrap of the frame counter.
// ---------------------------------------------------------------------------
module tb_matrix_result_serializer;

    logic         clk;
    logic         rst;
    logic [127:0] in_data;
    logic         in_ready;
    logic         in_ack;
    logic [31:0]  out_word;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [7:0]   out_frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cycles = 0;
    logic [31:0] q_word [$];
    logic        q_last [$];

    localparam logic [127:0] F1 = {32'h40A00000, 32'h41300000,
                                   32'h41300000, 32'h41C80000};
    localparam logic [127:0] F2 = {32'h3F800000, 32'h40000000,
                                   32'h40400000, 32'h40800000};

    logic [31:0] f1_order [4] = '{32'h40A00000, 32'h41300000,
                                  32'h41300000, 32'h41C80000};
`ifdef MATRIX_SER_COLMAJOR_EN
    logic [31:0] f2_order [4] = '{32'h3F800000, 32'h40400000,
                                  32'h40000000, 32'h40800000};
`else
    logic [31:0] f2_order [4] = '{32'h3F800000, 32'h40000000,
                                  32'h40400000, 32'h40800000};
`endif

    matrix_result_serializer #(
        .NUM_ROWS   (2),
        .NUM_COLS   (2),
        .WORD_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .In            (in_data),
        .in_ready      (in_ready),
        .in_ack        (in_ack),
        .out_word      (out_word),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .out_frame_cnt (out_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted beat, sampled half a cycle before its edge.
    always @(negedge clk) begin
        if (out_valid) valid_cycles++;
        if (out_valid && out_ready) begin
            q_word.push_back(out_word);
            q_last.push_back(out_last);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ack) return;
        end
        chk("ack_timeout", 32'(in_ack), 32'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!out_valid) return;
        end
        chk("idle_timeout", 32'(out_valid), 32'd0);
    endtask

    task automatic send_frame(input logic [127:0] data);
        tick();
        in_data  = data;
        in_ready = 1'b1;
        wait_ack();
        tick();
        in_ready = 1'b0;
        wait_idle();
    endtask

    task automatic check_frame(input string tag, input int base,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] exp_w [4];
        exp_w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_word%0d", tag, i), q_word[base+i], exp_w[i]);
            chk($sformatf("%s_last%0d", tag, i), 32'(q_last[base+i]),
                (i == 3) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        in_data   = '0;
        in_ready  = 1'b0;
        out_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ack",    32'(in_ack),        32'd0);
        chk("rst_out_valid", 32'(out_valid),     32'd0);
        chk("rst_out_word",  out_word,           32'd0);
        chk("rst_out_last",  32'(out_last),      32'd0);
        chk("rst_frame_cnt", 32'(out_frame_cnt), 32'd0);
        tick();
        rst = 1'b1;

        // 1. Basic frame; In changes after capture must not leak through.
        q_word.delete(); q_last.delete(); valid_cycles = 0;
        tick();
        in_data  = F1;
        in_ready = 1'b1;
        wait_ack();
        chk("t1_first_valid", 32'(out_valid), 32'd1);
        chk("t1_first_word",  out_word,       32'h40A00000);
        tick();
        in_ready = 1'b0;
        in_data  = {4{32'hDEADBEEF}};
        wait_idle();
        chk("t1_beats", 32'(q_word.size()), 32'd4);
        check_frame("t1", 0, f1_order[0], f1_order[1], f1_order[2], f1_order[3]);
        chk("t1_valid_cycles", 32'(valid_cycles),  32'd4);
        chk("t1_frame_cnt",    32'(out_frame_cnt), 32'd1);
        chk("t1_ack_released", 32'(in_ack),        32'd0);

        // 2. Backpressure on the second element for three edges.
        q_word.delete(); q_last.delete(); valid_cycles = 0;
        tick();
        in_data  = F1;
        in_ready = 1'b1;
        wait_ack();
        tick();
        in_ready  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t2_stall_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("t2_stall_word%0d", i),  out_word, 32'h41300000);
            chk($sformatf("t2_stall_last%0d", i),  32'(out_last), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle();
        chk("t2_beats", 32'(q_word.size()), 32'd4);
        check_frame("t2", 0, f1_order[0], f1_order[1], f1_order[2], f1_order[3]);
        chk("t2_valid_cycles", 32'(valid_cycles),  32'd7);
        chk("t2_frame_cnt",    32'(out_frame_cnt), 32'd2);

        // 3. in_ready held high for 20 cycles: exactly one frame.
        q_word.delete(); q_last.delete();
        tick();
        in_data  = F1;
        in_ready = 1'b1;
        repeat (20) tick();
        chk("t3_beats_held", 32'(q_word.size()),  32'd4);
        chk("t3_ack_held",   32'(in_ack),         32'd1);
        chk("t3_idle_held",  32'(out_valid),      32'd0);
        chk("t3_cnt_held",   32'(out_frame_cnt),  32'd3);
        in_ready = 1'b0;
        tick();
        chk("t3_ack_fell",   32'(in_ack),         32'd0);
        in_ready = 1'b1;
        wait_ack();
        tick();
        in_ready = 1'b0;
        wait_idle();
        chk("t3_beats_total", 32'(q_word.size()), 32'd8);
        check_frame("t3b", 4, f1_order[0], f1_order[1], f1_order[2], f1_order[3]);
        chk("t3_cnt_second", 32'(out_frame_cnt), 32'd4);

        // 4. Reset after the second beat.
        q_word.delete(); q_last.delete();
        tick();
        in_data  = F1;
        in_ready = 1'b1;
        wait_ack();
        tick();
        in_ready = 1'b0;
        tick();
        chk("t4_beats_before", 32'(q_word.size()), 32'd2);
        rst = 1'b0;
        #1;
        chk("t4_rst_valid", 32'(out_valid),     32'd0);
        chk("t4_rst_word",  out_word,           32'd0);
        chk("t4_rst_last",  32'(out_last),      32'd0);
        chk("t4_rst_ack",   32'(in_ack),        32'd0);
        chk("t4_rst_cnt",   32'(out_frame_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        q_word.delete(); q_last.delete();

        // 5. Element order for this build, fresh frame after reset.
        send_frame(F2);
        chk("t5_beats", 32'(q_word.size()), 32'd4);
        check_frame("t5", 0, f2_order[0], f2_order[1], f2_order[2], f2_order[3]);
        chk("t5_cnt", 32'(out_frame_cnt), 32'd1);

        // 6. Counter wrap: 256 frames since reset reads back 0.
        for (int k = 1; k <= 255; k++) begin
            q_word.delete(); q_last.delete();
            send_frame(F2);
            if (k == 254) chk("t6_cnt_255", 32'(out_frame_cnt), 32'd255);
        end
        chk("t6_cnt_wrap", 32'(out_frame_cnt), 32'd0);
        chk("t6_last_beats", 32'(q_word.size()), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
